// File: rtl/arp_hdr_gen.sv
// -----------------------------------------------------------------------------
// arp_hdr_gen
//   Writes a 42-byte Ethernet + ARP header, one byte per accepted strobe, into
//   an external header buffer. A rising edge on i_set_local latches the local
//   MAC/IP and writes the whole header (default request opcode, broadcast dst,
//   zero target). A rising edge on i_trig latches the destination MAC/IP and
//   the ARP mode, then rewrites only the 18 per-packet bytes (dst MAC, opcode,
//   target MAC, target IP).
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_set_local       level; rising edge starts a full-header write
//   i_trig            level; rising edge starts a variable-field write
//   i_mode            0 = ARP reply, 1 = ARP request (latched on i_trig)
//   i_mac, i_ip       address inputs; byte 0 is the most significant byte
//   i_hdr_stall       buffer back-pressure; a write completes when
//                     o_wr_hdr_en=1 and i_hdr_stall=0
//   o_hdr_idx         buffer address of the presented byte (HDR_BASE-relative)
//   o_hdr_byte        presented data byte
//   o_wr_hdr_en       write strobe
//   o_busy            sequence in progress (LATCH, WRITE, DONE)
//   o_ready           one-cycle pulse in the cycle after the last write
//   o_local_valid     a full header has completed since reset
//   o_err             one-cycle pulse when a trigger arrives with no local
//                     address configured
// -----------------------------------------------------------------------------
module arp_hdr_gen #(
    parameter int HDR_AW    = 6,
    parameter int HDR_BASE  = 0,
    parameter bit BCAST_REQ = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_set_local,
    input  logic              i_trig,
    input  logic              i_mode,
    input  logic [47:0]       i_mac,
    input  logic [31:0]       i_ip,
    input  logic              i_hdr_stall,
    output logic [HDR_AW-1:0] o_hdr_idx,
    output logic [7:0]        o_hdr_byte,
    output logic              o_wr_hdr_en,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_local_valid,
    output logic              o_err
);

    localparam logic [5:0] FULL_LEN = 6'd42;
    localparam logic [5:0] VAR_LEN  = 6'd18;
    localparam logic [HDR_AW-1:0] BASE_IDX = HDR_AW'(HDR_BASE);

    // The header must fit in the buffer without address wrap.
    if (HDR_BASE + 42 > (1 << HDR_AW)) begin : g_param_check
        $error("arp_hdr_gen: HDR_BASE+42 exceeds the header buffer size");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              set_prev_q, set_prev_d;
    logic              trig_prev_q, trig_prev_d;
    logic              full_q, full_d;
    logic              mode_q, mode_d;
    logic [47:0]       local_mac_q, local_mac_d;
    logic [31:0]       local_ip_q, local_ip_d;
    logic [47:0]       dst_mac_q, dst_mac_d;
    logic [31:0]       dst_ip_q, dst_ip_d;
    logic [5:0]        step_q, step_d;
    logic [HDR_AW-1:0] idx_q, idx_d;
    logic [7:0]        byte_q, byte_d;
    logic              en_q, en_d;
    logic              local_valid_q, local_valid_d;
    logic              err_q, err_d;

    logic              set_edge, trig_edge;
    logic [5:0]        seq_len;
    logic [5:0]        look_step;
    logic [5:0]        look_off;
    logic [7:0]        look_byte;
    logic [HDR_AW-1:0] look_idx;
    logic [47:0]       dmac_eff, tmac_eff;
    logic [31:0]       tip_eff;
    logic [7:0]        op_lo;

    // ---------------------------------------------------------------------
    // Byte-lookup helpers
    // ---------------------------------------------------------------------
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
        logic [7:0] b;
        case (k)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            default: b = mac[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = ip[31:24];
            2'd1:    b = ip[23:16];
            2'd2:    b = ip[15:8];
            default: b = ip[7:0];
        endcase
        return b;
    endfunction

    // Step -> header offset. The variable sequence visits four disjoint
    // ranges in ascending order, so each range is a constant shift of step.
    function automatic logic [5:0] step_to_off(input logic [5:0] step, input logic full);
        logic [5:0] off;
        if (full || step < 6'd6) begin
            off = step;
        end else if (step < 6'd8) begin
            off = step + 6'd14;
        end else begin
            off = step + 6'd24;
        end
        return off;
    endfunction

    function automatic logic [7:0] hdr_byte(
        input logic [5:0]  off,
        input logic [47:0] dmac,
        input logic [47:0] lmac,
        input logic [31:0] lip,
        input logic [47:0] tmac,
        input logic [31:0] tip,
        input logic [7:0]  opl
    );
        logic [7:0] b;
        if (off < 6'd6) begin
            b = mac_byte(dmac, off[2:0]);
        end else if (off < 6'd12) begin
            b = mac_byte(lmac, 3'(off - 6'd6));
        end else if (off < 6'd22) begin
            case (off)
                6'd12:   b = 8'h08;   // EtherType ARP
                6'd13:   b = 8'h06;
                6'd14:   b = 8'h00;   // HTYPE Ethernet
                6'd15:   b = 8'h01;
                6'd16:   b = 8'h08;   // PTYPE IPv4
                6'd17:   b = 8'h00;
                6'd18:   b = 8'h06;   // HLEN
                6'd19:   b = 8'h04;   // PLEN
                6'd20:   b = 8'h00;   // opcode high byte
                default: b = opl;     // opcode low byte
            endcase
        end else if (off < 6'd28) begin
            b = mac_byte(lmac, 3'(off - 6'd22));
        end else if (off < 6'd32) begin
            b = ip_byte(lip, 2'(off - 6'd28));
        end else if (off < 6'd38) begin
            b = mac_byte(tmac, 3'(off - 6'd32));
        end else begin
            b = ip_byte(tip, 2'(off - 6'd38));
        end
        return b;
    endfunction

    // ---------------------------------------------------------------------
    // Field values for the sequence in progress
    // ---------------------------------------------------------------------
    always_comb begin
        dmac_eff = dst_mac_q;
        tmac_eff = dst_mac_q;
        tip_eff  = dst_ip_q;
        op_lo    = mode_q ? 8'h01 : 8'h02;
        if (full_q) begin
            // Full write: broadcast dst, zero target, default request opcode.
            dmac_eff = '1;
            tmac_eff = '0;
            tip_eff  = '0;
            op_lo    = 8'h01;
        end else if (mode_q && BCAST_REQ) begin
            dmac_eff = '1;
            tmac_eff = '0;
        end
    end

    assign set_edge  = i_set_local & ~set_prev_q;
    assign trig_edge = i_trig & ~trig_prev_q;
    assign seq_len   = full_q ? FULL_LEN : VAR_LEN;

    // LATCH always presents step 0; WRITE presents the step held in step_q.
    assign look_step = (state_q == ST_LATCH) ? 6'd0 : step_q;
    assign look_off  = step_to_off(look_step, full_q);
    assign look_byte = hdr_byte(look_off, dmac_eff, local_mac_q, local_ip_q,
                                tmac_eff, tip_eff, op_lo);
    assign look_idx  = BASE_IDX + HDR_AW'(look_off);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        set_prev_d    = i_set_local;
        trig_prev_d   = i_trig;
        full_d        = full_q;
        mode_d        = mode_q;
        local_mac_d   = local_mac_q;
        local_ip_d    = local_ip_q;
        dst_mac_d     = dst_mac_q;
        dst_ip_d      = dst_ip_q;
        step_d        = step_q;
        idx_d         = idx_q;
        byte_d        = byte_q;
        en_d          = en_q;
        local_valid_d = local_valid_q;
        err_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // set_local has priority; a simultaneous trigger is dropped.
                if (set_edge) begin
                    full_d      = 1'b1;
                    local_mac_d = i_mac;
                    local_ip_d  = i_ip;
                    state_d     = ST_LATCH;
                end else if (trig_edge) begin
                    if (local_valid_q) begin
                        full_d    = 1'b0;
                        mode_d    = i_mode;
                        dst_mac_d = i_mac;
                        dst_ip_d  = i_ip;
                        state_d   = ST_LATCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                idx_d   = look_idx;
                byte_d  = look_byte;
                en_d    = 1'b1;
                step_d  = 6'd1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // step_q counts bytes presented so far; the last one is
                // accepted when step_q has reached the sequence length.
                if (!i_hdr_stall) begin
                    if (step_q == seq_len) begin
                        idx_d   = '0;
                        byte_d  = '0;
                        en_d    = 1'b0;
                        state_d = ST_DONE;
                        if (full_q) begin
                            local_valid_d = 1'b1;
                        end
                    end else begin
                        idx_d  = look_idx;
                        byte_d = look_byte;
                        step_d = step_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                step_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            set_prev_q    <= 1'b0;
            trig_prev_q   <= 1'b0;
            full_q        <= 1'b0;
            mode_q        <= 1'b0;
            local_mac_q   <= '0;
            local_ip_q    <= '0;
            dst_mac_q     <= '0;
            dst_ip_q      <= '0;
            step_q        <= '0;
            idx_q         <= '0;
            byte_q        <= '0;
            en_q          <= 1'b0;
            local_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            set_prev_q    <= set_prev_d;
            trig_prev_q   <= trig_prev_d;
            full_q        <= full_d;
            mode_q        <= mode_d;
            local_mac_q   <= local_mac_d;
            local_ip_q    <= local_ip_d;
            dst_mac_q     <= dst_mac_d;
            dst_ip_q      <= dst_ip_d;
            step_q        <= step_d;
            idx_q         <= idx_d;
            byte_q        <= byte_d;
            en_q          <= en_d;
            local_valid_q <= local_valid_d;
            err_q         <= err_d;
        end
    end

    assign o_hdr_idx     = idx_q;
    assign o_hdr_byte    = byte_q;
    assign o_wr_hdr_en   = en_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_ready       = (state_q == ST_DONE);
    assign o_local_valid = local_valid_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_arp_hdr_gen.sv
// -----------------------------------------------------------------------------
// tb_arp_hdr_gen
//   Directed bench for arp_hdr_gen with default parameters (HDR_AW=6,
//   HDR_BASE=0, BCAST_REQ=1). A negedge monitor mirrors every accepted write
//   into a local copy of the header buffer and logs address order and cycle
//   numbers; each scenario task compares that record against hand-built
//   expected header contents.
// -----------------------------------------------------------------------------
module tb_arp_hdr_gen;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_set_local;
    logic        i_trig;
    logic        i_mode;
    logic [47:0] i_mac;
    logic [31:0] i_ip;
    logic        i_hdr_stall;
    logic [5:0]  o_hdr_idx;
    logic [7:0]  o_hdr_byte;
    logic        o_wr_hdr_en;
    logic        o_busy;
    logic        o_ready;
    logic        o_local_valid;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int wr_total = 0;
    int ready_total = 0;
    int err_total = 0;
    int ready_cyc = 0;
    int err_cyc = 0;
    logic [5:0] wr_idx [0:511];
    int         wr_cyc [0:511];
    logic [7:0] mem    [0:63];
    logic [7:0] exp_buf[0:63];
    logic [5:0] var_ord[0:17];

    arp_hdr_gen dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_set_local  (i_set_local),
        .i_trig       (i_trig),
        .i_mode       (i_mode),
        .i_mac        (i_mac),
        .i_ip         (i_ip),
        .i_hdr_stall  (i_hdr_stall),
        .o_hdr_idx    (o_hdr_idx),
        .o_hdr_byte   (o_hdr_byte),
        .o_wr_hdr_en  (o_wr_hdr_en),
        .o_busy       (o_busy),
        .o_ready      (o_ready),
        .o_local_valid(o_local_valid),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_wr_hdr_en && !i_hdr_stall) begin
            wr_idx[wr_total] = o_hdr_idx;
            wr_cyc[wr_total] = cyc;
            mem[o_hdr_idx]   = o_hdr_byte;
            wr_total++;
        end
        if (o_ready) begin
            ready_total++;
            ready_cyc = cyc;
        end
        if (o_err) begin
            err_total++;
            err_cyc = cyc;
        end
    end

    task automatic exp_mac(input int off, input logic [47:0] m);
        for (int k = 0; k < 6; k++) exp_buf[off + k] = m[47 - 8 * k -: 8];
    endtask

    task automatic exp_ip(input int off, input logic [31:0] a);
        for (int k = 0; k < 4; k++) exp_buf[off + k] = a[31 - 8 * k -: 8];
    endtask

    task automatic exp_full(input logic [47:0] m, input logic [31:0] a);
        exp_mac(0, 48'hFFFF_FFFF_FFFF);
        exp_mac(6, m);
        exp_buf[12] = 8'h08; exp_buf[13] = 8'h06;
        exp_buf[14] = 8'h00; exp_buf[15] = 8'h01;
        exp_buf[16] = 8'h08; exp_buf[17] = 8'h00;
        exp_buf[18] = 8'h06; exp_buf[19] = 8'h04;
        exp_buf[20] = 8'h00; exp_buf[21] = 8'h01;
        exp_mac(22, m);
        exp_ip(28, a);
        exp_mac(32, 48'h0);
        exp_ip(38, 32'h0);
    endtask

    task automatic wait_ready(input int r0, output bit to);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready_total > r0) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_busy, o_wr_hdr_en, o_ready, o_local_valid, o_err, o_hdr_idx, o_hdr_byte} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs during reset: got idx=%h byte=%h en=%b busy=%b rdy=%b lv=%b err=%b, all required 0",
                     o_hdr_idx, o_hdr_byte, o_wr_hdr_en, o_busy, o_ready, o_local_valid, o_err);
        end
        @(posedge clk); #1;
        i_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({o_busy, o_wr_hdr_en, o_ready, o_local_valid, o_err, o_hdr_idx, o_hdr_byte} !== 19'd0) begin
            errors++;
            $display("FAIL reset_idle after release: got idx=%h byte=%h en=%b busy=%b lv=%b, all required 0",
                     o_hdr_idx, o_hdr_byte, o_wr_hdr_en, o_busy, o_local_valid);
        end
    endtask

    task automatic test_trig_no_local;
        int w0, e0, c0;
        @(posedge clk); #1;
        w0 = wr_total; e0 = err_total;
        i_mode = 1'b0; i_mac = 48'hAABB_CCDD_EEFF; i_ip = 32'hC0A8_0002;
        i_trig = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        i_trig = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err_total - e0 !== 1) begin
            errors++;
            $display("FAIL nolocal_err_count got %0d required 1", err_total - e0);
        end
        checks++;
        if (err_cyc !== c0 + 1) begin
            errors++;
            $display("FAIL nolocal_err_cycle got %0d required %0d", err_cyc, c0 + 1);
        end
        checks++;
        if (wr_total - w0 !== 0) begin
            errors++;
            $display("FAIL nolocal_strobes got %0d required 0", wr_total - w0);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL nolocal_busy got %b required 0", o_busy);
        end
    endtask

    task automatic test_full_write;
        int w0, r0, c0;
        bit to;
        @(posedge clk); #1;
        w0 = wr_total; r0 = ready_total;
        i_mac = 48'h0200_0000_0001; i_ip = 32'hC0A8_0001;
        i_set_local = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        i_set_local = 1'b0;
        wait_ready(r0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL full_timeout got no o_ready required one within 300 cycles");
        end
        checks++;
        if (wr_total - w0 !== 42) begin
            errors++;
            $display("FAIL full_count got %0d required 42", wr_total - w0);
        end
        checks++;
        if (wr_cyc[w0] !== c0 + 2) begin
            errors++;
            $display("FAIL full_first_latency got cycle %0d required %0d", wr_cyc[w0], c0 + 2);
        end
        checks++;
        if (wr_cyc[w0 + 41] - wr_cyc[w0] !== 41) begin
            errors++;
            $display("FAIL full_consecutive span got %0d required 41", wr_cyc[w0 + 41] - wr_cyc[w0]);
        end
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (wr_idx[w0 + i] !== 6'(i)) begin
                errors++;
                $display("FAIL full_order write %0d got idx %0d required %0d", i, wr_idx[w0 + i], i);
            end
        end
        exp_full(48'h0200_0000_0001, 32'hC0A8_0001);
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (mem[i] !== exp_buf[i]) begin
                errors++;
                $display("FAIL full_byte idx %0d got %h required %h", i, mem[i], exp_buf[i]);
            end
        end
        checks++;
        if ({mem[12], mem[28], mem[29], mem[30], mem[31]} !== 40'h08_C0_A8_00_01) begin
            errors++;
            $display("FAIL full_key_bytes got %h %h%h%h%h required 08 C0A80001",
                     mem[12], mem[28], mem[29], mem[30], mem[31]);
        end
        checks++;
        if (ready_cyc !== wr_cyc[w0 + 41] + 1) begin
            errors++;
            $display("FAIL full_ready_cycle got %0d required %0d", ready_cyc, wr_cyc[w0 + 41] + 1);
        end
        checks++;
        if (ready_total - r0 !== 1) begin
            errors++;
            $display("FAIL full_ready_count got %0d required 1", ready_total - r0);
        end
        checks++;
        if (o_local_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_local_valid got %b required 1", o_local_valid);
        end
    endtask

    task automatic test_reply;
        int w0, r0;
        bit to;
        @(posedge clk); #1;
        w0 = wr_total; r0 = ready_total;
        i_mode = 1'b0; i_mac = 48'hAABB_CCDD_EEFF; i_ip = 32'hC0A8_0002;
        i_trig = 1'b1;
        @(posedge clk); #1;
        i_trig = 1'b0;
        i_mac = 48'h0; i_ip = 32'h0; i_mode = 1'b1;
        wait_ready(r0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL reply_timeout got no o_ready required one within 300 cycles");
        end
        checks++;
        if (wr_total - w0 !== 18) begin
            errors++;
            $display("FAIL reply_count got %0d required 18", wr_total - w0);
        end
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (wr_idx[w0 + i] !== var_ord[i]) begin
                errors++;
                $display("FAIL reply_order write %0d got idx %0d required %0d", i, wr_idx[w0 + i], var_ord[i]);
            end
        end
        exp_mac(0, 48'hAABB_CCDD_EEFF);
        exp_buf[20] = 8'h00; exp_buf[21] = 8'h02;
        exp_mac(32, 48'hAABB_CCDD_EEFF);
        exp_ip(38, 32'hC0A8_0002);
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (mem[i] !== exp_buf[i]) begin
                errors++;
                $display("FAIL reply_byte idx %0d got %h required %h", i, mem[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_request;
        int w0, r0;
        bit to;
        @(posedge clk); #1;
        w0 = wr_total; r0 = ready_total;
        i_mode = 1'b1; i_mac = 48'h1122_3344_5566; i_ip = 32'hC0A8_0003;
        i_trig = 1'b1;
        @(posedge clk); #1;
        i_trig = 1'b0;
        wait_ready(r0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL request_timeout got no o_ready required one within 300 cycles");
        end
        checks++;
        if (wr_total - w0 !== 18) begin
            errors++;
            $display("FAIL request_count got %0d required 18", wr_total - w0);
        end
        exp_mac(0, 48'hFFFF_FFFF_FFFF);
        exp_buf[20] = 8'h00; exp_buf[21] = 8'h01;
        exp_mac(32, 48'h0);
        exp_ip(38, 32'hC0A8_0003);
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (mem[i] !== exp_buf[i]) begin
                errors++;
                $display("FAIL request_byte idx %0d got %h required %h", i, mem[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_stall;
        int w0, r0, c0;
        bit to;
        @(posedge clk); #1;
        w0 = wr_total; r0 = ready_total;
        i_mode = 1'b0; i_mac = 48'h0A0B_0C0D_0E0F; i_ip = 32'h0A00_0001;
        i_trig = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        i_trig = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        // Fifth write (offset 4) is on the bus now; hold it for 3 cycles.
        i_hdr_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if ({o_wr_hdr_en, o_hdr_idx, o_hdr_byte} !== {1'b1, 6'd4, 8'h0E}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got en=%b idx=%0d byte=%h required en=1 idx=4 byte=0e",
                         s, o_wr_hdr_en, o_hdr_idx, o_hdr_byte);
            end
            @(posedge clk); #1;
        end
        i_hdr_stall = 1'b0;
        wait_ready(r0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL stall_timeout got no o_ready required one within 300 cycles");
        end
        checks++;
        if (wr_total - w0 !== 18) begin
            errors++;
            $display("FAIL stall_count got %0d required 18", wr_total - w0);
        end
        checks++;
        if (wr_cyc[w0 + 4] !== c0 + 9) begin
            errors++;
            $display("FAIL stall_accept_cycle got %0d required %0d", wr_cyc[w0 + 4], c0 + 9);
        end
        checks++;
        if (wr_cyc[w0 + 17] - wr_cyc[w0] !== 20) begin
            errors++;
            $display("FAIL stall_span got %0d required 20", wr_cyc[w0 + 17] - wr_cyc[w0]);
        end
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (wr_idx[w0 + i] !== var_ord[i]) begin
                errors++;
                $display("FAIL stall_order write %0d got idx %0d required %0d", i, wr_idx[w0 + i], var_ord[i]);
            end
        end
        exp_mac(0, 48'h0A0B_0C0D_0E0F);
        exp_buf[20] = 8'h00; exp_buf[21] = 8'h02;
        exp_mac(32, 48'h0A0B_0C0D_0E0F);
        exp_ip(38, 32'h0A00_0001);
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (mem[i] !== exp_buf[i]) begin
                errors++;
                $display("FAIL stall_byte idx %0d got %h required %h", i, mem[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_simultaneous;
        int w0, r0, e0;
        bit to;
        @(posedge clk); #1;
        w0 = wr_total; r0 = ready_total; e0 = err_total;
        i_mode = 1'b0; i_mac = 48'h0200_0000_0009; i_ip = 32'hC0A8_0009;
        i_set_local = 1'b1; i_trig = 1'b1;
        @(posedge clk); #1;
        i_set_local = 1'b0; i_trig = 1'b0;
        wait_ready(r0, to);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL simul_timeout got no o_ready required one within 300 cycles");
        end
        checks++;
        if (wr_total - w0 !== 42) begin
            errors++;
            $display("FAIL simul_count got %0d required 42", wr_total - w0);
        end
        checks++;
        if (ready_total - r0 !== 1) begin
            errors++;
            $display("FAIL simul_ready_count got %0d required 1", ready_total - r0);
        end
        checks++;
        if (err_total - e0 !== 0) begin
            errors++;
            $display("FAIL simul_err got %0d pulses required 0", err_total - e0);
        end
        exp_full(48'h0200_0000_0009, 32'hC0A8_0009);
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (mem[i] !== exp_buf[i]) begin
                errors++;
                $display("FAIL simul_byte idx %0d got %h required %h", i, mem[i], exp_buf[i]);
            end
        end
    endtask

    task automatic test_rst_mid;
        int w0, e0, c0;
        @(posedge clk); #1;
        i_mac = 48'h0200_0000_0001; i_ip = 32'hC0A8_0001;
        i_set_local = 1'b1;
        @(posedge clk); #1;
        i_set_local = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({o_wr_hdr_en, o_hdr_idx} !== {1'b1, 6'd9}) begin
            errors++;
            $display("FAIL rstmid_position got en=%b idx=%0d required en=1 idx=9", o_wr_hdr_en, o_hdr_idx);
        end
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_busy, o_wr_hdr_en, o_ready, o_local_valid, o_err, o_hdr_idx, o_hdr_byte} !== 19'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got idx=%h byte=%h en=%b busy=%b rdy=%b lv=%b err=%b, all required 0",
                     o_hdr_idx, o_hdr_byte, o_wr_hdr_en, o_busy, o_ready, o_local_valid, o_err);
        end
        @(posedge clk); #1;
        w0 = wr_total; e0 = err_total;
        i_mode = 1'b0; i_mac = 48'hAABB_CCDD_EEFF; i_ip = 32'hC0A8_0002;
        i_trig = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        i_trig = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err_total - e0 !== 1) begin
            errors++;
            $display("FAIL rstmid_err_count got %0d required 1", err_total - e0);
        end
        checks++;
        if (err_cyc !== c0 + 1) begin
            errors++;
            $display("FAIL rstmid_err_cycle got %0d required %0d", err_cyc, c0 + 1);
        end
        checks++;
        if (wr_total - w0 !== 0) begin
            errors++;
            $display("FAIL rstmid_strobes got %0d required 0", wr_total - w0);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_set_local = 1'b0; i_trig = 1'b0; i_mode = 1'b0;
        i_mac = 48'h0; i_ip = 32'h0; i_hdr_stall = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'h00;
            exp_buf[i] = 8'h00;
        end
        for (int i = 0; i < 6; i++) var_ord[i] = 6'(i);
        var_ord[6] = 6'd20;
        var_ord[7] = 6'd21;
        for (int i = 0; i < 10; i++) var_ord[8 + i] = 6'(32 + i);

        test_reset();
        test_trig_no_local();
        test_full_write();
        test_reply();
        test_request();
        test_stall();
        test_simultaneous();
        test_rst_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
